// File: rtl/xram_mmio_bridge_if.sv
// CPU XRAM port and AES command port of the XRAM/MMIO bridge.
// The master side (CPU plus AES environment) drives the opcode, address and AES read data.
interface xram_mmio_bridge_if;
  logic [7:0]  pc_in;
  logic [15:0] xram_addr;
  logic [7:0]  xram_wdata;
  logic [7:0]  xram_rdata;
  logic        xram_rvalid;
  logic [1:0]  aes_cmd;
  logic [15:0] aes_addr;
  logic [7:0]  aes_wdata;
  logic [7:0]  aes_rdata;

  modport master (
    output pc_in, xram_addr, xram_wdata, aes_rdata,
    input  xram_rdata, xram_rvalid, aes_cmd, aes_addr, aes_wdata
  );

  modport slave (
    input  pc_in, xram_addr, xram_wdata, aes_rdata,
    output xram_rdata, xram_rvalid, aes_cmd, aes_addr, aes_wdata
  );
endinterface

// File: rtl/xram_mmio_bridge.sv
// Decodes oc8051 MOVX opcodes and routes each access to the AES MMIO window or a local
// scratch XRAM. Key registers are write-only; key reads and busy-time accesses are violations.
module xram_mmio_bridge #(
  parameter logic [15:0] AES_BASE   = 16'hFF00,
  parameter int unsigned AES_SIZE   = 64,
  parameter logic [15:0] KEY_LO     = 16'hFF10,
  parameter logic [15:0] KEY_HI     = 16'hFF1F,
  parameter int unsigned MEM_AW     = 8,
  parameter int unsigned AES_RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  xram_mmio_bridge_if.slave  bus,
  output logic               busy,
  output logic               viol,
  output logic [7:0]         viol_cnt
);

  localparam int unsigned MEM_DEPTH = 2 ** MEM_AW;
  localparam int unsigned CNT_W     = 2;
  localparam logic [16:0] AES_END   = 17'(AES_BASE) + 17'(AES_SIZE);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [15:0]        addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               wr_q, wr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic [1:0]         cmd_q, cmd_d;
  logic [15:0]        aes_addr_q, aes_addr_d;
  logic [7:0]         aes_wdata_q, aes_wdata_d;
  logic               busy_q, busy_d;
  logic               viol_q, viol_d;
  logic [7:0]         viol_cnt_q, viol_cnt_d;
  logic               dec_wr, dec_rd, viol_evt, mem_we;
  logic [7:0]         mem [MEM_DEPTH];

  function automatic logic in_aes(input logic [15:0] a);
    return (17'(a) >= 17'(AES_BASE)) && (17'(a) < AES_END);
  endfunction

  function automatic logic in_key(input logic [15:0] a);
    return (a >= KEY_LO) && (a <= KEY_HI);
  endfunction

  // MOVX opcode decode
  always_comb begin
    dec_wr = 1'b0;
    dec_rd = 1'b0;
    case (bus.pc_in)
      8'hF0, 8'hF2, 8'hF3: dec_wr = 1'b1;
      8'hE0, 8'hE2, 8'hE3: dec_rd = 1'b1;
      default: ;
    endcase
  end

  // Next state and next registered outputs; AES strobes are set on entry to ISSUE
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    cmd_d       = 2'b00;
    aes_addr_d  = 16'h0000;
    aes_wdata_d = 8'h00;
    viol_evt    = 1'b0;
    mem_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (dec_wr || dec_rd) begin
          state_d = ISSUE;
          addr_d  = bus.xram_addr;
          wdata_d = bus.xram_wdata;
          wr_d    = dec_wr;
          if (in_aes(bus.xram_addr) && (dec_wr || !in_key(bus.xram_addr))) begin
            cmd_d       = {dec_wr, dec_rd};
            aes_addr_d  = bus.xram_addr;
            aes_wdata_d = dec_wr ? bus.xram_wdata : 8'h00;
          end
        end
      end
      ISSUE: begin
        if (in_aes(addr_q)) begin
          if (wr_q) begin
            state_d = IDLE;
          end else if (in_key(addr_q)) begin
            rdata_d  = 8'h00;
            rvalid_d = 1'b1;
            viol_evt = 1'b1;
            state_d  = RESP;
          end else if (AES_RD_LAT == 1) begin
            rdata_d  = bus.aes_rdata;
            rvalid_d = 1'b1;
            state_d  = RESP;
          end else begin
            cnt_d   = CNT_W'(AES_RD_LAT - 1);
            state_d = WAIT;
          end
        end else if (wr_q) begin
          mem_we  = 1'b1;
          state_d = IDLE;
        end else begin
          rdata_d  = mem[addr_q[MEM_AW-1:0]];
          rvalid_d = 1'b1;
          state_d  = RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rdata_d  = bus.aes_rdata;
          rvalid_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Accesses are accepted only in IDLE; anything else is dropped and flagged
    if ((state_q != IDLE) && (dec_wr || dec_rd)) viol_evt = 1'b1;

    busy_d     = (state_d != IDLE);
    viol_d     = viol_q | viol_evt;
    viol_cnt_d = (viol_evt && (viol_cnt_q != 8'hFF)) ? viol_cnt_q + 8'd1 : viol_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= 16'h0000;
      wdata_q     <= 8'h00;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      rdata_q     <= 8'h00;
      rvalid_q    <= 1'b0;
      cmd_q       <= 2'b00;
      aes_addr_q  <= 16'h0000;
      aes_wdata_q <= 8'h00;
      busy_q      <= 1'b0;
      viol_q      <= 1'b0;
      viol_cnt_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      cmd_q       <= cmd_d;
      aes_addr_q  <= aes_addr_d;
      aes_wdata_q <= aes_wdata_d;
      busy_q      <= busy_d;
      viol_q      <= viol_d;
      viol_cnt_q  <= viol_cnt_d;
    end
  end

  // Scratch XRAM keeps its contents across reset; a write caught by reset is abandoned
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[addr_q[MEM_AW-1:0]] <= wdata_q;
  end

  assign bus.xram_rdata  = rdata_q;
  assign bus.xram_rvalid = rvalid_q;
  assign bus.aes_cmd     = cmd_q;
  assign bus.aes_addr    = aes_addr_q;
  assign bus.aes_wdata   = aes_wdata_q;
  assign busy            = busy_q;
  assign viol            = viol_q;
  assign viol_cnt        = viol_cnt_q;

endmodule

// File: tb/tb_xram_mmio_bridge.sv
// Bench for xram_mmio_bridge: a transaction-schedule model predicts every output each cycle,
// with directed scenarios pinned to hand-computed values followed by a randomized run.
module tb_xram_mmio_bridge;
  localparam int unsigned LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, viol;
  logic [7:0] viol_cnt;

  always #5 clk = ~clk;

  xram_mmio_bridge_if bus();

  xram_mmio_bridge #(.AES_RD_LAT(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .busy     (busy),
    .viol     (viol),
    .viol_cnt (viol_cnt)
  );

  int tests = 0, errors = 0;
  logic chk_en = 1'b0;

  // Model: ring of per-cycle expected outputs, indexed by cycle number mod 16
  int cyc = 0, idle_from = 0;
  logic [7:0]  mmem [256];
  logic [1:0]  s_cmd [16];
  logic [15:0] s_addr [16];
  logic [7:0]  s_wd [16];
  logic        s_rv [16];
  logic [7:0]  s_rd [16];
  logic        s_kv [16];
  logic [1:0]  e_cmd = 2'b00;
  logic [15:0] e_addr = 16'h0;
  logic [7:0]  e_wd = 8'h0, e_rd = 8'h0, e_cnt = 8'h0;
  logic        e_rv = 1'b0, e_busy = 1'b0, e_viol = 1'b0;

  logic [15:0] bnd [8];
  logic [1:0]  bnd_cmd [8];

  function automatic logic is_wr(input logic [7:0] p);
    return p == 8'hF0 || p == 8'hF2 || p == 8'hF3;
  endfunction
  function automatic logic is_rd(input logic [7:0] p);
    return p == 8'hE0 || p == 8'hE2 || p == 8'hE3;
  endfunction
  function automatic logic in_win(input logic [15:0] a);
    return a >= 16'hFF00 && a <= 16'hFF3F;
  endfunction
  function automatic logic in_key(input logic [15:0] a);
    return a >= 16'hFF10 && a <= 16'hFF1F;
  endfunction

  // Schedule the visible effects of an access accepted in cycle t
  task automatic accept(input int t, input logic wr, input logic [15:0] a,
                        input logic [7:0] d, input logic [7:0] ar);
    int n1;
    n1 = (t + 1) % 16;
    if (wr) begin
      if (in_win(a)) begin
        s_cmd[n1] = 2'b10; s_addr[n1] = a; s_wd[n1] = d;
      end else begin
        mmem[a[7:0]] = d;
      end
      idle_from = t + 2;
    end else if (in_win(a) && in_key(a)) begin
      s_kv[n1] = 1'b1;
      s_rv[(t + 2) % 16] = 1'b1; s_rd[(t + 2) % 16] = 8'h00;
      idle_from = t + 3;
    end else if (in_win(a)) begin
      s_cmd[n1] = 2'b01; s_addr[n1] = a; s_wd[n1] = 8'h00;
      s_rv[(t + 1 + LAT) % 16] = 1'b1; s_rd[(t + 1 + LAT) % 16] = ar;
      idle_from = t + 2 + LAT;
    end else begin
      s_rv[(t + 2) % 16] = 1'b1; s_rd[(t + 2) % 16] = mmem[a[7:0]];
      idle_from = t + 3;
    end
  endtask

  always @(posedge clk) begin : model
    int t, n;
    logic wr, rd, ev;
    t = cyc;
    n = (t + 1) % 16;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        s_cmd[i] = 2'b00; s_addr[i] = 16'h0; s_wd[i] = 8'h0;
        s_rv[i] = 1'b0; s_rd[i] = 8'h0; s_kv[i] = 1'b0;
      end
      e_cmd = 2'b00; e_addr = 16'h0; e_wd = 8'h0; e_rv = 1'b0; e_rd = 8'h0;
      e_busy = 1'b0; e_viol = 1'b0; e_cnt = 8'h0;
      idle_from = t + 1;
    end else begin
      wr = is_wr(bus.pc_in);
      rd = is_rd(bus.pc_in);
      ev = s_kv[t % 16];
      s_kv[t % 16] = 1'b0;
      if (wr || rd) begin
        if (t >= idle_from) accept(t, wr, bus.xram_addr, bus.xram_wdata, bus.aes_rdata);
        else ev = 1'b1;
      end
      if (ev) begin
        e_viol = 1'b1;
        if (e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
      end
      e_cmd = s_cmd[n]; e_addr = s_addr[n]; e_wd = s_wd[n]; e_rv = s_rv[n];
      if (s_rv[n]) e_rd = s_rd[n];
      s_cmd[n] = 2'b00; s_addr[n] = 16'h0; s_wd[n] = 8'h0; s_rv[n] = 1'b0;
      e_busy = (t + 1) < idle_from;
    end
    cyc = t + 1;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("aes_cmd",     16'(bus.aes_cmd),     16'(e_cmd));
      check("aes_addr",    bus.aes_addr,         e_addr);
      check("aes_wdata",   16'(bus.aes_wdata),   16'(e_wd));
      check("xram_rvalid", 16'(bus.xram_rvalid), 16'(e_rv));
      check("xram_rdata",  16'(bus.xram_rdata),  16'(e_rd));
      check("busy",        16'(busy),            16'(e_busy));
      check("viol",        16'(viol),            16'(e_viol));
      check("viol_cnt",    16'(viol_cnt),        16'(e_cnt));
    end
  end

  task automatic step(input logic [7:0] p, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.pc_in = p; bus.xram_addr = a; bus.xram_wdata = d;
  endtask

  task automatic nop(input int k);
    for (int i = 0; i < k; i++) step(8'h00, 16'h0000, 8'h00);
  endtask

  initial begin
    bus.pc_in = 8'h00; bus.xram_addr = 16'h0; bus.xram_wdata = 8'h0; bus.aes_rdata = 8'h0;
    bnd     = '{16'hFEFF, 16'hFF00, 16'hFF0F, 16'hFF10, 16'hFF1F, 16'hFF20, 16'hFF3F, 16'hFF40};
    bnd_cmd = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    bnd_cmd[1] = 2'b01; bnd_cmd[2] = 2'b01; bnd_cmd[5] = 2'b01; bnd_cmd[6] = 2'b01;

    // Reset state
    nop(3);
    chk_en = 1'b1;
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_viol_cnt", 16'(viol_cnt), 16'h0);
    check("rst_aes_cmd", 16'(bus.aes_cmd), 16'h0);
    check("rst_rdata", 16'(bus.xram_rdata), 16'h0);
    rst = 1'b0;

    // Fill the whole scratch memory through aliased addresses outside the window
    for (int i = 0; i < 256; i++) begin
      step(8'hF0, {8'($urandom_range(0, 254)), 8'(i)}, 8'($urandom));
      nop(1);
    end

    // Scratch round trip
    step(8'hF0, 16'h0012, 8'hA5); nop(1);
    step(8'hE0, 16'h0012, 8'h00); nop(2);
    check("scr_rvalid", 16'(bus.xram_rvalid), 16'h1);
    check("scr_rdata", 16'(bus.xram_rdata), 16'h00A5);
    nop(1);
    check("scr_rvalid_pulse", 16'(bus.xram_rvalid), 16'h0);

    // Scratch wrap
    step(8'hF0, 16'h0105, 8'h3C); nop(1);
    step(8'hE0, 16'h0005, 8'h00); nop(2);
    check("wrap_rdata", 16'(bus.xram_rdata), 16'h003C);

    // AES write then read
    step(8'hF2, 16'hFF20, 8'h77); nop(1);
    check("aesw_cmd", 16'(bus.aes_cmd), 16'h2);
    check("aesw_addr", bus.aes_addr, 16'hFF20);
    check("aesw_wdata", 16'(bus.aes_wdata), 16'h0077);
    nop(1);
    check("aesw_cmd_off", 16'(bus.aes_cmd), 16'h0);
    bus.aes_rdata = 8'h9E;
    step(8'hE2, 16'hFF20, 8'h00); nop(1);
    check("aesr_cmd", 16'(bus.aes_cmd), 16'h1);
    nop(LAT);
    check("aesr_rvalid", 16'(bus.xram_rvalid), 16'h1);
    check("aesr_rdata", 16'(bus.xram_rdata), 16'h009E);
    nop(2);

    // Key protection
    step(8'hF3, 16'hFF15, 8'h5A); nop(1);
    check("keyw_cmd", 16'(bus.aes_cmd), 16'h2);
    nop(1);
    step(8'hE3, 16'hFF15, 8'h00); nop(1);
    check("keyr_cmd", 16'(bus.aes_cmd), 16'h0);
    nop(1);
    check("keyr_rvalid", 16'(bus.xram_rvalid), 16'h1);
    check("keyr_rdata", 16'(bus.xram_rdata), 16'h0000);
    check("keyr_viol", 16'(viol), 16'h1);
    check("keyr_viol_cnt", 16'(viol_cnt), 16'h1);
    nop(2);

    // Busy drop: AES and scratch writes arriving mid-read are ignored
    step(8'hF0, 16'h0040, 8'h11); nop(1);
    bus.aes_rdata = 8'hC4;
    step(8'hE0, 16'hFF30, 8'h00);
    step(8'hF2, 16'hFF21, 8'hEE);
    step(8'hF0, 16'h0040, 8'hEE);
    nop(2);
    check("drop_rvalid", 16'(bus.xram_rvalid), 16'h1);
    check("drop_rdata", 16'(bus.xram_rdata), 16'h00C4);
    check("drop_viol_cnt", 16'(viol_cnt), 16'h3);
    nop(2);
    step(8'hE0, 16'h0040, 8'h00); nop(2);
    check("drop_mem", 16'(bus.xram_rdata), 16'h0011);
    nop(2);

    // Window and key boundaries
    for (int i = 0; i < 8; i++) begin
      step(8'hE0, bnd[i], 8'h00); nop(1);
      check("bnd_cmd", 16'(bus.aes_cmd), 16'(bnd_cmd[i]));
      nop(LAT + 2);
    end

    // Reset in WAIT, then a normal scratch read
    bus.aes_rdata = 8'h3D;
    step(8'hE0, 16'hFF30, 8'h00); nop(2);
    check("mid_busy", 16'(busy), 16'h1);
    rst = 1'b1;
    nop(1);
    rst = 1'b0;
    check("mid_rst_busy", 16'(busy), 16'h0);
    check("mid_rst_viol", 16'(viol), 16'h0);
    check("mid_rst_cnt", 16'(viol_cnt), 16'h0);
    check("mid_rst_rvalid", 16'(bus.xram_rvalid), 16'h0);
    check("mid_rst_rdata", 16'(bus.xram_rdata), 16'h0000);
    step(8'hE0, 16'h0012, 8'h00); nop(1);
    check("mid_aes_cmd", 16'(bus.aes_cmd), 16'h0);
    nop(1);
    check("post_rst_rvalid", 16'(bus.xram_rvalid), 16'h1);
    check("post_rst_rdata", 16'(bus.xram_rdata), 16'h00A5);
    nop(2);

    // Randomized traffic, dense enough to saturate the violation counter
    for (int k = 0; k < 3000; k++) begin
      logic [7:0]  p;
      logic [15:0] a;
      case ($urandom_range(0, 9))
        0: p = 8'hF0;
        1: p = 8'hF2;
        2: p = 8'hF3;
        3: p = 8'hE0;
        4: p = 8'hE2;
        5: p = 8'hE3;
        default: p = 8'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: a = {8'($urandom_range(0, 254)), 8'($urandom)};
        1: a = 16'hFF00 + 16'($urandom_range(0, 63));
        2: a = bnd[$urandom_range(0, 7)];
        default: a = 16'($urandom);
      endcase
      @(negedge clk);
      if (cyc >= idle_from) bus.aes_rdata = 8'($urandom);
      bus.pc_in = p; bus.xram_addr = a; bus.xram_wdata = 8'($urandom);
    end
    nop(LAT + 3);
    check("sat_viol", 16'(viol), 16'h1);
    check("sat_viol_cnt", 16'(viol_cnt), 16'h00FF);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
